count_event_monitor: RTL and testbench

//  Downstream consumer of the 8-bit free-running counter's count output.

---
 rtl/count_event_monitor.sv | 167 ++++++++++++++++
 tb/tb_count_event_monitor.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_event_monitor.sv
// count_event_monitor: timestamps counter wrap/match/stall events and
// queues them in a small FIFO drained over a valid/ready handshake.
// Ports: clk, rst (async, active-low), count_in, cmp_val, cmp_en,
//   evt_ready | evt_valid, evt_data {flags,epoch,count}, epoch,
//   epoch_ovf, drop_cnt, fifo_level, stalled.
// Optional feature macro: STALL_DETECT_EN (stall run detection).
module count_event_monitor #(
  parameter int EPOCH_W      = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  count_in,
  input  logic [7:0]                  cmp_val,
  input  logic                        cmp_en,
  input  logic                        evt_ready,
  output logic                        evt_valid,
  output logic [EPOCH_W+10:0]         evt_data,
  output logic [EPOCH_W-1:0]          epoch,
  output logic                        epoch_ovf,
  output logic [7:0]                  drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        stalled
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = EPOCH_W + 11;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  logic [7:0]         r_cur;
  logic [7:0]         r_prev;
  logic               r_cur_vld;
  logic               r_prev_vld;
  logic [EPOCH_W-1:0] r_epoch;
  logic               r_ovf;
  logic [7:0]         r_drop;
  logic [DW-1:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr;
  logic [AW-1:0]      r_rd;
  logic [AW:0]        r_lvl;

  logic               w_wrap;
  logic               w_match;
  logic               w_stall;
  logic [2:0]         w_flags;
  logic               w_push;
  logic               w_pop;
  logic               w_valid;
  logic               w_full;
  logic               w_wr_en;
  logic               w_drop;
  logic [EPOCH_W-1:0] w_epoch_nxt;
  logic [DW-1:0]      w_entry;

  // Two valid stages so the compare pair never mixes a real sample
  // with the reset value of r_prev.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur      <= '0;
      r_prev     <= '0;
      r_cur_vld  <= 1'b0;
      r_prev_vld <= 1'b0;
    end else begin
      r_cur      <= count_in;
      r_prev     <= r_cur;
      r_cur_vld  <= 1'b1;
      r_prev_vld <= r_cur_vld;
    end
  end

  assign w_wrap = r_prev_vld
               && r_prev == 8'hFF
               && r_cur  == 8'h00;

  assign w_match = r_prev_vld && cmp_en
                && r_cur == cmp_val
                && r_cur != r_prev;

`ifdef STALL_DETECT_EN
  localparam int RW = $clog2(STALL_CYCLES + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(STALL_CYCLES - 1);

  logic [RW-1:0] r_run;
  logic          r_stalled;
  logic          w_same;

  assign w_same  = r_prev_vld && r_cur == r_prev;
  // Fires once per run; r_stalled blocks re-fire until count moves.
  assign w_stall = w_same && !r_stalled && r_run == RUN_LAST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run     <= '0;
      r_stalled <= 1'b0;
    end else if (!w_same) begin
      r_run     <= '0;
      r_stalled <= 1'b0;
    end else if (w_stall) begin
      r_stalled <= 1'b1;
    end else if (!r_stalled) begin
      r_run <= r_run + 1'b1;
    end
  end

  assign stalled = r_stalled;
`else
  assign w_stall = 1'b0;
  assign stalled = 1'b0;
`endif

  assign w_flags = {w_stall, w_match, w_wrap};
  assign w_push  = |w_flags;
  assign w_valid = r_lvl != '0;
  assign w_full  = r_lvl == FULL_LVL;
  assign w_pop   = w_valid && evt_ready;
  // A pop frees the slot the same cycle, so full+push+pop is legal.
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  assign w_epoch_nxt = r_epoch
                     + {{(EPOCH_W-1){1'b0}}, w_wrap};
  assign w_entry = {w_flags, w_epoch_nxt, r_cur};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_epoch <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_epoch <= w_epoch_nxt;
      if (w_wrap && (&r_epoch))
        r_ovf <= 1'b1;
      if (w_drop && r_drop != 8'hFF)
        r_drop <= r_drop + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_lvl <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr] <= w_entry;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      if (w_wr_en && !w_pop)
        r_lvl <= r_lvl + 1'b1;
      else if (!w_wr_en && w_pop)
        r_lvl <= r_lvl - 1'b1;
    end
  end

  assign evt_valid  = w_valid;
  assign evt_data   = w_valid ? r_mem[r_rd] : '0;
  assign epoch      = r_epoch;
  assign epoch_ovf  = r_ovf;
  assign drop_cnt   = r_drop;
  assign fifo_level = r_lvl;

endmodule

// File: tb/tb_count_event_monitor.sv
// tb_count_event_monitor: directed bench for count_event_monitor.
// Two DUTs: default widths, and EPOCH_W=2 for epoch rollover.
module tb_count_event_monitor;

  logic        clk;
  logic        rst;
  logic        rst2;
  logic [7:0]  count_in;
  logic [7:0]  cmp_val;
  logic        cmp_en;
  logic        evt_ready;

  logic        evt_valid;
  logic [18:0] evt_data;
  logic [7:0]  epoch;
  logic        epoch_ovf;
  logic [7:0]  drop_cnt;
  logic [2:0]  fifo_level;
  logic        stalled;

  logic        evt_valid2;
  logic [12:0] evt_data2;
  logic [1:0]  epoch2;
  logic        epoch_ovf2;
  logic [7:0]  drop_cnt2;
  logic [2:0]  fifo_level2;
  logic        stalled2;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef STALL_DETECT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  count_event_monitor u_dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .cmp_val    (cmp_val),
    .cmp_en     (cmp_en),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .epoch      (epoch),
    .epoch_ovf  (epoch_ovf),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level),
    .stalled    (stalled)
  );

  count_event_monitor #(.EPOCH_W(2)) u_dut2 (
    .clk        (clk),
    .rst        (rst2),
    .count_in   (count_in),
    .cmp_val    (cmp_val),
    .cmp_en     (cmp_en),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid2),
    .evt_data   (evt_data2),
    .epoch      (epoch2),
    .epoch_ovf  (epoch_ovf2),
    .drop_cnt   (drop_cnt2),
    .fifo_level (fifo_level2),
    .stalled    (stalled2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Ticks n cycles, counting cycles with evt_valid (ready held 1).
  task automatic tick_cnt(input int n, output int nv,
                          output logic [18:0] last);
    nv   = 0;
    last = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (evt_valid) begin
        nv++;
        last = evt_data;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(3);
  endtask

  localparam logic [18:0] E0 = {3'b010, 8'd0, 8'h05};
  localparam logic [18:0] E1 = {3'b001, 8'd1, 8'h00};
  localparam logic [18:0] E2 = {3'b010, 8'd1, 8'h05};
  localparam logic [18:0] E3 = {3'b001, 8'd2, 8'h00};
  localparam logic [18:0] E4 = {3'b010, 8'd3, 8'h05};

  initial begin
    int          nv;
    int          tot;
    logic [18:0] last;
    logic [7:0]  seq [9];

    rst       = 1'b0;
    rst2      = 1'b0;
    count_in  = 8'h00;
    cmp_val   = 8'h00;
    cmp_en    = 1'b0;
    evt_ready = 1'b1;
    tick(2);
    check("rst_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_epoch", {24'd0, epoch}, 32'd0);
    check("rst_drop", {24'd0, drop_cnt}, 32'd0);

    // Plain ramp with one wrap
    rst = 1'b1;
    tick(3);
    tot = 0;
    for (int v = 1; v < 256; v++) begin
      count_in = 8'(v);
      tick_cnt(1, nv, last);
      tot += nv;
    end
    check("ramp_quiet", tot, 0);
    count_in = 8'h00;
    tick(1);
    check("wrap_lat_n", {31'd0, evt_valid}, 32'd0);
    tick(1);
    check("wrap_valid", {31'd0, evt_valid}, 32'd1);
    check("wrap_data", {13'd0, evt_data}, {13'd0, E1});
    check("wrap_epoch", {24'd0, epoch}, 32'd1);
    check("wrap_level", {29'd0, fifo_level}, 32'd1);
    tick(1);
    check("wrap_popped", {29'd0, fifo_level}, 32'd0);

    // Wrap coinciding with match on 00
    cmp_en  = 1'b1;
    cmp_val = 8'h00;
    count_in = 8'h00;
    do_reset();
    tot = 0;
    for (int v = 1; v < 256; v++) begin
      count_in = 8'(v);
      tick_cnt(1, nv, last);
      tot += nv;
    end
    check("ramp2_quiet", tot, 0);
    count_in = 8'h00;
    tick_cnt(2, nv, last);
    check("merge_cnt", nv, 1);
    check("merge_data", {13'd0, last},
          {13'd0, 3'b011, 8'd1, 8'h00});
    tick_cnt(10, nv, last);
    check("hold_nomatch", nv, 0);

    // First post-reset sample equals cmp_val
    cmp_val  = 8'h33;
    count_in = 8'h33;
    do_reset();
    tick_cnt(5, nv, last);
    check("first_sample", nv, 0);

    // Overfill with ready low
    cmp_val   = 8'h05;
    count_in  = 8'h00;
    evt_ready = 1'b0;
    do_reset();
    seq = '{8'h05, 8'hFF, 8'h00, 8'h05, 8'hFF,
            8'h00, 8'h05, 8'hFF, 8'h00};
    foreach (seq[i]) begin
      count_in = seq[i];
      tick(1);
    end
    tick(2);
    check("full_level", {29'd0, fifo_level}, 32'd4);
    check("full_drop", {24'd0, drop_cnt}, 32'd2);
    check("full_epoch", {24'd0, epoch}, 32'd3);
    check("hold_head", {13'd0, evt_data}, {13'd0, E0});

    // Push and pop on the same edge while full
    count_in = 8'h05;
    tick(1);
    check("pp_pre_lvl", {29'd0, fifo_level}, 32'd4);
    evt_ready = 1'b1;
    check("drain_e0", {13'd0, evt_data}, {13'd0, E0});
    tick(1);
    check("pp_level", {29'd0, fifo_level}, 32'd4);
    check("pp_drop", {24'd0, drop_cnt}, 32'd2);
    check("drain_e1", {13'd0, evt_data}, {13'd0, E1});
    tick(1);
    check("drain_e2", {13'd0, evt_data}, {13'd0, E2});
    check("drain_lvl3", {29'd0, fifo_level}, 32'd3);
    tick(1);
    check("drain_e3", {13'd0, evt_data}, {13'd0, E3});
    tick(1);
    check("drain_e4", {13'd0, evt_data}, {13'd0, E4});
    tick(1);
    check("drain_empty", {31'd0, evt_valid}, 32'd0);
    check("drain_lvl0", {29'd0, fifo_level}, 32'd0);

    // Drop counter saturation
    evt_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      count_in = 8'h04;
      tick(1);
      count_in = 8'h05;
      tick(1);
    end
    tick(1);
    check("drop_sat", {24'd0, drop_cnt}, 32'd255);
    check("sat_level", {29'd0, fifo_level}, 32'd4);

    // Asynchronous reset between edges
    #3;
    rst = 1'b0;
    #1;
    check("async_rst", {12'd0, evt_valid, evt_data, epoch,
          epoch_ovf, drop_cnt, fifo_level, stalled}, 32'd0);

    // Narrow epoch rollover
    cmp_en    = 1'b0;
    evt_ready = 1'b1;
    count_in  = 8'h00;
    tick(1);
    rst2 = 1'b1;
    tick(3);
    for (int k = 0; k < 4; k++) begin
      count_in = 8'hFF;
      tick(1);
      count_in = 8'h00;
      tick(2);
      check($sformatf("ep2_%0d", k), {30'd0, epoch2},
            32'((k + 1) % 4));
      check($sformatf("ovf2_%0d", k), {31'd0, epoch_ovf2},
            32'(k == 3));
    end
    evt_ready = 1'b0;
    count_in  = 8'hFF;
    tick(1);
    count_in = 8'h00;
    tick(2);
    check("ep2_busy", {31'd0, evt_valid2}, 32'd1);
    #3;
    rst2 = 1'b0;
    #1;
    check("async_rst2", {evt_valid2, evt_data2, epoch2,
          epoch_ovf2, drop_cnt2, fifo_level2, stalled2}, 32'd0);

    // Stall detection (or its absence)
    evt_ready = 1'b1;
    count_in  = 8'h00;
    do_reset();
    count_in = 8'h07;
    tick_cnt(20, nv, last);
    check("stall_cnt", nv, STALL_ON ? 1 : 0);
    check("stall_data", {13'd0, last}, STALL_ON ?
          {13'd0, 3'b100, 8'd0, 8'h07} : 32'd0);
    check("stall_lvl", {31'd0, stalled}, {31'd0, STALL_ON});
    count_in = 8'h08;
    tick(2);
    check("stall_clr", {31'd0, stalled}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
